// File: rtl/cgra_kernel_scheduler.sv
// Round-robin launch queue that runs CGRA kernels one at a time: start, wait for done, notify.
// Define CGRA_SCHED_WDT_EN to add a watchdog that aborts kernels stuck in WAIT for TIMEOUT cycles.
module cgra_kernel_scheduler #(
  parameter int NREQ    = 2,
  parameter int KID_W   = 4,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic                                   clk_i,
  input  logic                                   rst_i,
  input  logic [NREQ-1:0]                        req_valid_i,
  input  logic [NREQ*KID_W-1:0]                  req_kernel_i,
  output logic [NREQ-1:0]                        req_ready_o,
  input  logic                                   cgra_enable_i,
  output logic                                   cgra_start_o,
  output logic [KID_W-1:0]                       cgra_kernel_o,
  input  logic                                   cgra_done_i,
  output logic                                   done_valid_o,
  output logic [((NREQ > 1) ? $clog2(NREQ) : 1)-1:0] done_req_o,
  output logic                                   done_err_o,
  output logic [NREQ-1:0]                        irq_o,
  input  logic [NREQ-1:0]                        irq_clear_i,
  output logic                                   busy_o,
  output logic [$clog2(DEPTH+1)-1:0]             fifo_count_o,
  output logic                                   err_o
);

  localparam int RW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  typedef enum logic [1:0] {IDLE, START, WAIT, DONE} state_e;
  state_e state_q, state_d;

  logic [RW-1:0]       rr_q, rr_d, winner;
  logic                found;
  logic [NREQ-1:0]     grant;
  logic [KID_W-1:0]    win_kid;
  logic                push, pop, full, empty;
  logic [RW+KID_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]       count_q;
  logic [KID_W-1:0]    kernel_q;
  logic [RW-1:0]       cur_req_q, done_req_q;
  logic                start_q, done_valid_q, busy_q;
  logic [NREQ-1:0]     irq_q, irq_set;
  logic                finish, wdt_fire;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);

  // Two passes give "first valid at or after the pointer, wrapping" with constant indices.
  always_comb begin : arbiter
    found   = 1'b0;
    winner  = '0;
    win_kid = '0;
    grant   = '0;
    for (int r = 0; r < NREQ; r++) begin
      if (!found && req_valid_i[r] && (RW'(r) >= rr_q)) begin
        found  = 1'b1;
        winner = RW'(r);
      end
    end
    for (int r = 0; r < NREQ; r++) begin
      if (!found && req_valid_i[r]) begin
        found  = 1'b1;
        winner = RW'(r);
      end
    end
    for (int r = 0; r < NREQ; r++) begin
      if (winner == RW'(r)) win_kid = req_kernel_i[r*KID_W +: KID_W];
      grant[r] = found && !full && !rst_i && (winner == RW'(r));
    end
  end

  assign push = |grant;
  assign pop  = (state_q == IDLE) && !empty && cgra_enable_i;

  always_comb begin
    rr_d = rr_q;
    if (push) rr_d = (winner == RW'(NREQ-1)) ? '0 : winner + 1'b1;
  end

  always_comb begin : fsm_next
    state_d = state_q;
    finish  = 1'b0;
    case (state_q)
      IDLE:  if (pop) state_d = START;
      START: state_d = WAIT;
      WAIT: begin
        if (cgra_done_i || wdt_fire) begin
          state_d = DONE;
          finish  = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    irq_set = '0;
    for (int r = 0; r < NREQ; r++) irq_set[r] = finish && (cur_req_q == RW'(r));
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      rr_q         <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      kernel_q     <= '0;
      cur_req_q    <= '0;
      start_q      <= 1'b0;
      done_valid_q <= 1'b0;
      done_req_q   <= '0;
      busy_q       <= 1'b0;
      irq_q        <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      if (push) begin
        mem_q[wr_ptr_q] <= {winner, win_kid};
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        {cur_req_q, kernel_q} <= mem_q[rd_ptr_q];
        rd_ptr_q              <= rd_ptr_q + 1'b1;
      end
      count_q      <= count_q + CW'(push) - CW'(pop);
      start_q      <= (state_d == START);
      busy_q       <= (state_d != IDLE);
      done_valid_q <= finish;
      done_req_q   <= finish ? cur_req_q : '0;
      // A set landing on the same edge as its clear takes priority.
      irq_q        <= (irq_q & ~irq_clear_i) | irq_set;
    end
  end

`ifdef CGRA_SCHED_WDT_EN
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [TW-1:0] wdt_q;
  logic          done_err_q, err_q;

  // A done arriving in the timeout cycle suppresses the abort.
  assign wdt_fire = (state_q == WAIT) && !cgra_done_i && (wdt_q == TW'(TIMEOUT-1));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wdt_q      <= '0;
      done_err_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      wdt_q      <= (state_q == WAIT) ? wdt_q + 1'b1 : '0;
      done_err_q <= wdt_fire;
      err_q      <= err_q | wdt_fire;
    end
  end

  assign done_err_o = done_err_q;
  assign err_o      = err_q;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT != 0);
  assign wdt_fire       = 1'b0;
  assign done_err_o     = 1'b0;
  assign err_o          = 1'b0;
`endif

  assign req_ready_o   = grant;
  assign cgra_start_o  = start_q;
  assign cgra_kernel_o = kernel_q;
  assign done_valid_o  = done_valid_q;
  assign done_req_o    = done_req_q;
  assign irq_o         = irq_q;
  assign busy_o        = busy_q;
  assign fifo_count_o  = count_q;

endmodule

// File: doc/cgra_kernel_scheduler.md
# cgra_kernel_scheduler

Queues CGRA kernel launch requests from several requesters, such as the host CPU, a DMA-driven job list or a debug port. Requests are accepted through round-robin arbitration into an in-order FIFO. The block sequences the CGRA one kernel at a time: start pulse, wait for done, completion notification. It sits between the peripheral-side request logic and the CGRA top wrapper's start/done controls, in the same clock domain as the wrapper. It produces per-requester sticky interrupt bits, which are ORed into the external interrupt vector.

## Interface
Parameters:
- NREQ, 2, number of requesters (≥1)
- KID_W, 4, kernel identifier width
- DEPTH, 4, launch FIFO depth (power of two, ≥2)
- TIMEOUT, 1024, watchdog limit in cycles (used only with CGRA_SCHED_WDT_EN)

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset; **one clock; reset is synchronous and active-high**
- req_valid_i  in  NREQ  launch request valid, one bit per requester
- req_kernel_i  in  NREQ*KID_W  kernel id; requester r uses bits [r*KID_W +: KID_W]
- req_ready_o  out  NREQ  one-hot grant; handshake when valid&ready on the same bit
- cgra_enable_i  in  1  when low, no new launch begins
- cgra_start_o  out  1  single-cycle start pulse to the CGRA
- cgra_kernel_o  out  KID_W  kernel id of the current launch; held stable from START through WAIT
- cgra_done_i  in  1  CGRA kernel-complete pulse
- done_valid_o  out  1  single-cycle completion notification
- done_req_o  out  $clog2(NREQ) (min 1)  requester index of the completed kernel
- done_err_o  out  1  completion was a watchdog abort
- irq_o  out  NREQ  sticky per-requester completion interrupt
- irq_clear_i  in  NREQ  per-bit clear pulse
- busy_o  out  1  FSM not in IDLE
- fifo_count_o  out  $clog2(DEPTH+1)  queued entries
- err_o  out  1  sticky watchdog error

## Operation
Arbitration:
- Round-robin pointer p, reset value 0.
- When the FIFO is not full, req_ready_o has exactly one bit set: the first valid requester at or after p, wrapping modulo NREQ.
- When the FIFO is full, or no requester is valid, req_ready_o is all zeros.
- On a handshake, p becomes winner+1 mod NREQ.
- At most one push per cycle.
- Each FIFO entry holds {requester index, kernel id}.

FIFO:
- Push and pop in the same cycle are allowed, including when the FIFO is full (pop frees space, but ready was already low that cycle) and when it is empty (no pop occurs).
- Pointers wrap modulo DEPTH.

FSM states: IDLE, START, WAIT, DONE.
- IDLE → START when FIFO not empty and cgra_enable_i=1. The head is popped and latched into cgra_kernel_o and the current requester register.
- START: cgra_start_o=1 for exactly one cycle, then go to WAIT. cgra_done_i is ignored in START.
- WAIT → DONE on cgra_done_i=1.
- DONE: done_valid_o=1 with done_req_o set and done_err_o as applicable. irq_o[done_req_o] is set. Go to IDLE.
- If cgra_enable_i falls during START, WAIT or DONE, the FSM continues; the enable only gates new launches from IDLE.

Interrupts:
- irq_clear_i[r] clears irq_o[r].
- If set and clear hit the same bit in the same cycle, set wins.

Reset:
- While rst_i is high, all of the following are 0: every output, p, FIFO contents, pointers, count, irq_o, err_o.
- The FSM returns to IDLE.
- Reset asserted mid-kernel aborts tracking. A cgra_done_i arriving after reset is ignored, because the FSM is in IDLE.

## Timing
- Handshake in cycle t → fifo_count_o increments at t+1.
- With the FSM in IDLE and cgra_enable_i=1: pop at t+1, cgra_start_o at t+2.
- cgra_done_i in cycle d → done_valid_o and the irq_o set both visible at d+1 → IDLE at d+2.
- Minimum back-to-back spacing between start pulses: 4 cycles (START, WAIT with immediate done, DONE, IDLE).
- busy_o is registered and equals (state != IDLE).
- All outputs are registered except req_ready_o, which is combinational from req_valid_i, p and the full flag.

## Configuration
CGRA_SCHED_WDT_EN:
- Defined:
  - A cycle counter clears on entry to WAIT and increments each WAIT cycle.
  - If it reaches TIMEOUT-1 without cgra_done_i, the FSM goes to DONE with done_err_o=1 and err_o is set (sticky until rst_i).
  - irq_o is still set for the requester.
  - If cgra_done_i arrives in the same cycle as the timeout, done wins and done_err_o=0.
- Undefined: no counter, done_err_o and err_o tied 0, and WAIT lasts indefinitely.

## Test plan
- Single launch: req 0 kernel 5 at cycle 0 → cgra_start_o at cycle 2 with cgra_kernel_o=5; done_i at cycle 10 → done_valid_o at 11 with done_req_o=0, irq_o=01; irq_clear_i=01 → irq_o=00.
- Round-robin: both requesters hold valid with kernels 1 and 2 for 4 cycles, FIFO has room → grants alternate 0,1,0,1; launches execute in the same order.
- Full FIFO: with DEPTH=4 and the CGRA stalled in WAIT, submit 5 requests → 4 accepted, req_ready_o=0 and fifo_count_o=4; after done, the 5th is accepted.
- Enable gating: queue 1 entry with cgra_enable_i=0 for 20 cycles → no start; raise enable → start_o 1 cycle later.
- Reset mid-kernel: rst_i in WAIT with 2 entries queued, then done_i → no done_valid_o, fifo_count_o=0, all outputs 0.
- WDT (CGRA_SCHED_WDT_EN, TIMEOUT=16): no done_i → done_valid_o with done_err_o=1 and err_o=1 after 16 WAIT cycles; separately, done_i coincident with the timeout → done_err_o=0.
